// File: rtl/cache_ctrl.sv
// Read-only 2-way set-associative cache controller: 4 sets x 2 ways, 8-bit data,
// shared by two requesters through round-robin arbitration, with a blocking
// single-outstanding miss path to backing memory.
module cache_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt
);

    typedef enum logic [1:0] {StIdle, StLookup, StFill, StResp} state_t;

    state_t     state_q, state_d;
    logic       rr_q;
    logic       gid_q;
    logic [7:0] addr_q;
    logic       ack0_q, ack1_q;
    logic [7:0] rdata_q;
    logic       mem_req_q;
    logic [7:0] mem_addr_q;
    logic [7:0] hit_q, miss_q;

    logic [1:0] valid_q [4];
    logic [3:0] lru_q;
    logic [7:0] data_arr [4][2];
    logic [5:0] tag_arr  [4][2];

    logic [1:0] set_idx;
    logic [5:0] tag_in;
    logic       hit0, hit1, hit, hit_way, victim, grant_id, any_req, fill_done;

    // Lookup, victim choice and arbitration decode from the latched request.
    always_comb begin
        set_idx   = addr_q[1:0];
        tag_in    = addr_q[7:2];
        hit0      = valid_q[set_idx][0] && (tag_arr[set_idx][0] == tag_in);
        hit1      = valid_q[set_idx][1] && (tag_arr[set_idx][1] == tag_in);
        hit       = hit0 || hit1;
        hit_way   = !hit0;
        if (!valid_q[set_idx][0]) begin
            victim = 1'b0;
        end else if (!valid_q[set_idx][1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[set_idx];
        end
        any_req   = req0 || req1;
        grant_id  = (req0 && req1) ? rr_q : req1;
        fill_done = (state_q == StFill) && mem_ack;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StLookup;
            StLookup: state_d = hit ? StResp : StFill;
            StFill:   if (mem_ack) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register plus all registered outputs and control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            gid_q      <= 1'b0;
            addr_q     <= 8'h00;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata_q    <= 8'h00;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 8'h00;
            hit_q      <= 8'h00;
            miss_q     <= 8'h00;
            lru_q      <= 4'h0;
            for (int i = 0; i < 4; i++) valid_q[i] <= 2'b00;
        end else begin
            state_q <= state_d;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gid_q  <= grant_id;
                        addr_q <= grant_id ? addr1 : addr0;
                    end
                end
                StLookup: begin
                    if (hit) begin
                        rdata_q        <= data_arr[set_idx][hit_way];
                        lru_q[set_idx] <= ~hit_way;
                        if (hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
                        ack0_q         <= !gid_q;
                        ack1_q         <= gid_q;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_q;
                        if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
                    end
                end
                StFill: begin
                    if (mem_ack) begin
                        valid_q[set_idx][victim] <= 1'b1;
                        lru_q[set_idx]           <= ~victim;
                        rdata_q                  <= mem_rdata;
                        mem_req_q                <= 1'b0;
                        ack0_q                   <= !gid_q;
                        ack1_q                   <= gid_q;
                    end
                end
                StResp: rr_q <= ~gid_q;
                default: ;
            endcase
        end
    end

    // Data/tag storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            data_arr[set_idx][victim] <= mem_rdata;
            tag_arr[set_idx][victim]  <= tag_in;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign busy     = (state_q != StIdle);
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: stimulus pushes expected responses, a monitor
// pops and compares on every ack, and a memory model answers mem_req.
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic       ack0, ack1;
    logic [7:0] rdata;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;
    logic [7:0] hit_cnt, miss_cnt;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] maddr_q[$];
    int         vectors = 0;
    int         errors = 0;
    int         mem_lat = 3;
    int         mem_cnt = 0;
    bit         hold = 0;
    bit         spurious = 0;
    int         exp_hit = 0;
    int         exp_miss = 0;

    // Backing memory contents: 0x15 -> 0xA5.
    function automatic logic [7:0] mem_data(input logic [7:0] a);
        return a ^ 8'hB0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack0 || ack1) begin
                check("single ack", int'(ack0 && ack1), 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected ack: ack0=%0b ack1=%0b expected none", ack0, ack1);
                end else begin
                    e = exp_q.pop_front();
                    check("ack id", int'(ack1), int'(e.id));
                    check("rdata", int'(rdata), int'(e.data));
                end
            end
        end
    end

    // Memory model: acks after mem_lat cycles, checks the requested address.
    initial begin
        int wctr = 0;
        logic [7:0] ea;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (spurious) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
            end else if (mem_req && !hold) begin
                wctr++;
                if (wctr >= mem_lat) begin
                    wctr      = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data(mem_addr);
                    mem_cnt++;
                    if (maddr_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected mem_req: addr 0x%0h expected none", mem_addr);
                    end else begin
                        ea = maddr_q.pop_front();
                        check("mem_addr", int'(mem_addr), int'(ea));
                    end
                end
            end else begin
                wctr = 0;
            end
        end
    end

    task automatic bump(input bit miss);
        if (miss) begin
            if (exp_miss < 255) exp_miss++;
        end else begin
            if (exp_hit < 255) exp_hit++;
        end
    endtask

    task automatic check_counters();
        check("hit_cnt", int'(hit_cnt), exp_hit);
        check("miss_cnt", int'(miss_cnt), exp_miss);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        exp_q.delete();
        maddr_q.delete();
    endtask

    task automatic read_one(input logic id, input logic [7:0] a, input bit miss);
        int n = 0;
        int m0;
        bit got = 0;
        wait_idle();
        exp_q.push_back({id, mem_data(a)});
        if (miss) maddr_q.push_back(a);
        m0 = mem_cnt;
        if (id) begin
            req1 = 1'b1;
            addr1 = a;
        end else begin
            req0 = 1'b1;
            addr0 = a;
        end
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (id ? ack1 : ack0) got = 1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL read timeout: addr 0x%0h no ack within %0d cycles", a, n);
        end else begin
            check("latency", n, miss ? mem_lat + 2 : 2);
        end
        check("mem reads", mem_cnt - m0, miss ? 1 : 0);
        bump(miss);
        check_counters();
    endtask

    task automatic read_pair(input logic [7:0] a0, input logic [7:0] a1, input bit miss);
        int n = 0;
        bit d0 = 0, d1 = 0;
        int first = -1;
        wait_idle();
        exp_q.push_back({1'b0, mem_data(a0)});
        exp_q.push_back({1'b1, mem_data(a1)});
        if (miss) begin
            maddr_q.push_back(a0);
            maddr_q.push_back(a1);
        end
        req0 = 1'b1; addr0 = a0;
        req1 = 1'b1; addr1 = a1;
        while (!(d0 && d1) && n < 100) begin
            @(negedge clk);
            n++;
            if (ack0) begin
                req0 = 1'b0;
                d0 = 1;
                if (first < 0) first = 0;
            end
            if (ack1) begin
                req1 = 1'b0;
                d1 = 1;
                if (first < 0) first = 1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!(d0 && d1)) begin
            vectors++;
            errors++;
            $display("FAIL pair timeout: ack0 seen %0b ack1 seen %0b, both required", d0, d1);
        end
        check("first served", first, 0);
        bump(miss);
        bump(miss);
        check_counters();
    endtask

    // Abort a pending fill with reset, then poke a stray mem_ack.
    task automatic reset_mid_fill();
        int n = 0;
        wait_idle();
        hold  = 1;
        req0  = 1'b1;
        addr0 = 8'h40;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort mem_req seen", int'(mem_req), 1);
        check("abort mem_addr", int'(mem_addr), 8'h40);
        rst = 1'b1;
        @(negedge clk);
        check("mem_req after rst", int'(mem_req), 0);
        check("busy after rst", int'(busy), 0);
        rst  = 1'b0;
        req0 = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
        spurious = 1;
        repeat (2) @(negedge clk);
        spurious = 0;
        repeat (2) @(negedge clk);
        check("stray ack busy", int'(busy), 0);
        check("stray ack mem_req", int'(mem_req), 0);
        check_counters();
        hold = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("reset ack0", int'(ack0), 0);
        check("reset ack1", int'(ack1), 0);
        check("reset mem_req", int'(mem_req), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset rdata", int'(rdata), 0);
        check("reset busy", int'(busy), 0);
        check_counters();

        // Cold miss then hit on the same line.
        read_one(1'b0, 8'h15, 1'b1);
        read_one(1'b0, 8'h15, 1'b0);

        // Simultaneous requests: 0 first both times.
        do_reset();
        read_pair(8'h02, 8'h03, 1'b1);
        read_pair(8'h02, 8'h03, 1'b0);

        // LRU replacement within set 1.
        do_reset();
        read_one(1'b0, 8'h01, 1'b1);
        read_one(1'b1, 8'h05, 1'b1);
        read_one(1'b0, 8'h01, 1'b0);
        read_one(1'b1, 8'h09, 1'b1);
        read_one(1'b0, 8'h01, 1'b0);
        read_one(1'b0, 8'h05, 1'b1);

        // Reset during fill clears valid bits.
        reset_mid_fill();
        read_one(1'b0, 8'h01, 1'b1);
        read_one(1'b1, 8'h15, 1'b1);
        read_one(1'b0, 8'h01, 1'b0);

        // 300 misses cycling 64 tags through set 0.
        for (int i = 0; i < 300; i++) begin
            read_one(i[0], 8'((i % 64) * 4), 1'b1);
        end
        check("miss_cnt saturated", int'(miss_cnt), 255);
        check("hit_cnt kept", int'(hit_cnt), 1);

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 req0 / req1  in  1  read request from requester 0 / 1; held high with address stable until the matching ack.
REQ-005 addr0 / addr1  in  8  byte address for requester 0 / 1: tag = addr[7:2], set index = addr[1:0].
REQ-006 ack0 / ack1  out  1  one-cycle pulse; rdata is valid in that cycle for that requester.
REQ-007 rdata  out  8  read data, shared by both requesters; holds its last value between responses.
REQ-008 mem_req  out  1  backing-memory read request; held high until mem_ack.
REQ-009 mem_addr  out  8  backing-memory address; stable while mem_req is high.
REQ-010 mem_ack  in  1  memory response strobe; mem_rdata is valid in the same cycle.
REQ-011 mem_rdata  in  8  memory read data.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 hit_cnt / miss_cnt  out  8  saturating lookup-result counters.

Function
REQ-014 SHALL own a 2-way set-associative store: 4 sets x 2 ways, each entry holding 8-bit data, a 6-bit tag and a valid bit, plus 1 LRU bit per set (the LRU bit names the next victim way).
REQ-015 FSM states: IDLE, LOOKUP, FILL, RESP; all outputs registered.
REQ-016 IDLE: if req0 or req1 is high, grant one requester, latch its address and id, and go to LOOKUP; otherwise stay in IDLE.
REQ-017 Arbitration: round-robin pointer rr. When both requesters are requesting, grant requester rr. When one is requesting, grant that one. After each RESP, rr = the requester not just served.
REQ-018 LOOKUP, hit (valid and tag match in way w, way0 checked first): rdata <= data[w]; LRU <= ~w; hit_cnt+1; go to RESP.
REQ-019 LOOKUP, miss: mem_req <= 1; mem_addr <= latched address; miss_cnt+1; go to FILL.
REQ-020 Victim selection: first invalid way (way0 if both ways are invalid); otherwise the way named by the set's LRU bit.
REQ-021 FILL: mem_ack is sampled each cycle, including the first FILL cycle. On the edge where mem_ack is sampled high: write mem_rdata, tag and valid=1 into the victim way; LRU <= ~victim; rdata <= mem_rdata; mem_req <= 0; go to RESP.
REQ-022 FILL has no timeout: mem_req and mem_addr stay constant until mem_ack.
REQ-023 mem_ack outside FILL SHALL be ignored, with no state or array change.
REQ-024 RESP: ack of the granted requester is high for exactly this one cycle; the other ack stays 0; next state is IDLE.
REQ-025 Hit latency: ack is high in the cycle that starts 2 edges after the IDLE edge that accepted the request.
REQ-026 Miss latency: ack is high in the cycle that starts at the edge where mem_ack is sampled high.
REQ-027 Requesters drop req at the edge that samples ack high. A req still high in IDLE is treated as a new request.
REQ-028 Requests arriving while busy are not lost; they wait, with req held, until IDLE.
REQ-029 hit_cnt and miss_cnt saturate at 255 and never wrap.
REQ-030 ack0 and ack1 are never high in the same cycle; at most one lookup is outstanding.

Reset
REQ-031 When rst is sampled high: state=IDLE, rr=0, all valid=0, all LRU=0, ack0=ack1=0, mem_req=0, mem_addr=0, rdata=0, hit_cnt=miss_cnt=0. Data and tag arrays are not reset.
REQ-032 Reset has priority in every state. Reset during FILL: mem_req is 0 from the next cycle, no array write occurs, and no ack is issued for the aborted request.

Verification
REQ-033 Cold miss: after reset, req0 with addr0=0x15; memory acks 3 cycles after mem_req with 0xA5 -> mem_addr=0x15, one ack0 pulse with rdata=0xA5, miss_cnt=1.
REQ-034 Hit: then req0 with addr0=0x15 -> no mem_req, ack0 2 cycles after acceptance with rdata=0xA5, hit_cnt=1.
REQ-035 LRU: fill 0x01 then 0x05 (both set 1), read 0x01 (hit), then read 0x09 (miss) -> 0x09 replaces 0x05's way; 0x01 still hits; 0x05 misses.
REQ-036 Arbitration: req0 (0x02) and req1 (0x03) raised in the same cycle after reset -> ack0 first, then ack1. Repeating the simultaneous pair serves requester 0 first again (rr=0 after serving 1).
REQ-037 Reset mid-FILL: rst asserted while mem_req=1 -> mem_req=0 the next cycle, no ack. A later mem_ack is ignored. Re-reading any previously filled address misses.
REQ-038 Saturation: 300 distinct-tag misses -> miss_cnt=255 and hit_cnt unchanged.
